// File: rtl/lsu_axi.sv
// Load/store unit bridging execute to an AXI-lite data bus: lane alignment, strobes,
// load extension, fault detection and a registered valid/ready writeback.
module lsu_axi #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_reg_we,
    output logic              out_err,
    output logic [1:0]        out_err_code,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

    state_t            state_reg;
    logic [OFF_W-1:0]  off_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;

    logic              illegal;
    logic              misaligned;
    logic [OFF_W-1:0]  amask;
    logic [STRB_W-1:0] strb_base;
    logic [STRB_W-1:0] wstrb_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] load_data;

    // Shift the addressed field down to bit 0, then zero- or sign-fill above it.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [1:0]        sz,
                                                  input logic              sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        logic              sb;
        int                nb;
        sh  = d >> {off, 3'b000};
        nb  = 8 << sz;
        sb  = 1'b0;
        res = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nb - 1) sb = sh[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < nb) ? sh[i] : (sgn & sb);
        end
        return res;
    endfunction

    always_comb begin
        illegal   = (in_ren && in_wen) || (int'(in_size) > OFF_W);
        amask     = '0;
        strb_base = '0;
        for (int i = 0; i < OFF_W; i++) amask[i] = (i < int'(in_size));
        for (int i = 0; i < STRB_W; i++) strb_base[i] = (i < (1 << in_size));
        misaligned = |(in_addr[OFF_W-1:0] & amask);
        wstrb_next = strb_base << in_addr[OFF_W-1:0];
        wdata_next = in_wdata << {in_addr[OFF_W-1:0], 3'b000};
        load_data  = extract(rdata, off_reg, size_reg, signed_reg);
    end

    assign in_ready  = (state_reg == IDLE);
    assign rready    = (state_reg == RDATA);
    assign bready    = (state_reg == WRESP);
    assign out_valid = (state_reg == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            off_reg      <= '0;
            size_reg     <= '0;
            signed_reg   <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_reg_we   <= 1'b0;
            out_err      <= 1'b0;
            out_err_code <= '0;
            araddr       <= '0;
            arsize       <= '0;
            arvalid      <= 1'b0;
            awaddr       <= '0;
            awsize       <= '0;
            awvalid      <= 1'b0;
            wdata        <= '0;
            wstrb        <= '0;
            wvalid       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        out_rd       <= in_rd;
                        out_reg_we   <= in_reg_we;
                        off_reg      <= in_addr[OFF_W-1:0];
                        size_reg     <= in_size;
                        signed_reg   <= in_signed;
                        out_data     <= '0;
                        out_err      <= 1'b0;
                        out_err_code <= '0;
                        if (illegal) begin
                            out_err      <= 1'b1;
                            out_err_code <= ERR_ILLEGAL;
                            state_reg    <= DONE;
                        end else if (misaligned) begin
                            out_err      <= 1'b1;
                            out_err_code <= ERR_MISALIGN;
                            state_reg    <= DONE;
                        end else if (in_ren) begin
                            araddr    <= in_addr;
                            arsize    <= {1'b0, in_size};
                            arvalid   <= 1'b1;
                            state_reg <= RADDR;
                        end else if (in_wen) begin
                            awaddr    <= in_addr;
                            awsize    <= {1'b0, in_size};
                            wdata     <= wdata_next;
                            wstrb     <= wstrb_next;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            state_reg <= WREQ;
                        end else begin
                            out_data  <= in_wdata;
                            state_reg <= DONE;
                        end
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid   <= 1'b0;
                        state_reg <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        state_reg <= DONE;
                        if (rresp != 2'b00) begin
                            out_err      <= 1'b1;
                            out_err_code <= ERR_BUS;
                            out_data     <= '0;
                        end else begin
                            out_data <= load_data;
                        end
                    end
                end
                WREQ: begin
                    // AW and W retire independently; leave once neither is still pending.
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready) wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) state_reg <= WRESP;
                end
                WRESP: begin
                    if (bvalid) begin
                        state_reg <= DONE;
                        if (bresp != 2'b00) begin
                            out_err      <= 1'b1;
                            out_err_code <= ERR_BUS;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axi.sv
// Directed bench for lsu_axi: a 64-bit instance for loads/stores/faults and a
// 32-bit instance for the illegal-size and ren+wen cases.
module tb_lsu_axi;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        in_valid = 0, in_ren = 0, in_wen = 0, in_signed = 0, in_reg_we = 0;
    logic [1:0]  in_size = 0;
    logic [31:0] in_addr = 0;
    logic [63:0] in_wdata = 0;
    logic [4:0]  in_rd = 0;
    logic        in_ready, out_valid, out_reg_we, out_err;
    logic        out_ready = 0;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  out_err_code;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
    logic [63:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;

    // 32-bit instance
    logic        s_in_valid = 0, s_in_ren = 0, s_in_wen = 0;
    logic [1:0]  s_in_size = 0;
    logic        s_in_ready, s_out_valid, s_out_reg_we, s_out_err;
    logic [31:0] s_out_data, s_araddr, s_awaddr, s_wdata;
    logic [4:0]  s_out_rd;
    logic [1:0]  s_out_err_code;
    logic [2:0]  s_arsize, s_awsize;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [3:0]  s_wstrb;

    lsu_axi #(.ADDR_W(32), .DATA_W(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren),
        .in_wen(in_wen), .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .in_reg_we(in_reg_we), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_reg_we(out_reg_we),
        .out_err(out_err), .out_err_code(out_err_code), .araddr(araddr), .arsize(arsize),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready));

    lsu_axi #(.ADDR_W(32), .DATA_W(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ren(s_in_ren),
        .in_wen(s_in_wen), .in_size(s_in_size), .in_signed(1'b0), .in_addr(32'h0),
        .in_wdata(32'h0), .in_rd(5'd0), .in_reg_we(1'b0), .out_valid(s_out_valid),
        .out_ready(1'b1), .out_data(s_out_data), .out_rd(s_out_rd), .out_reg_we(s_out_reg_we),
        .out_err(s_out_err), .out_err_code(s_out_err_code), .araddr(s_araddr),
        .arsize(s_arsize), .arvalid(s_arvalid), .arready(1'b1), .rdata(32'h0),
        .rresp(2'b00), .rvalid(1'b1), .rready(s_rready), .awaddr(s_awaddr),
        .awsize(s_awsize), .awvalid(s_awvalid), .awready(1'b1), .wdata(s_wdata),
        .wstrb(s_wstrb), .wvalid(s_wvalid), .wready(1'b1), .bresp(2'b00), .bvalid(1'b1),
        .bready(s_bready));

    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, s_bus_cnt = 0;
    always @(posedge clk) begin
        if (arvalid && arready) ar_cnt <= ar_cnt + 1;
        if (awvalid && awready) aw_cnt <= aw_cnt + 1;
        if (wvalid && wready) w_cnt <= w_cnt + 1;
        if (s_arvalid || s_awvalid || s_wvalid) s_bus_cnt <= s_bus_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    int snap_ar, snap_aw, snap_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a load, check AR on cycle 1, return rdata on cycle 2, check result on cycle 3.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [63:0] rd, input logic [1:0] rr,
                           input logic [63:0] exp_d, input logic [1:0] exp_c);
        in_valid = 1; in_ren = 1; in_wen = 0; in_size = sz; in_signed = sg; in_addr = a;
        arready = 1;
        tick;
        in_valid = 0; in_ren = 0;
        chk({tag, "_arvalid"}, 64'(arvalid), 64'd1);
        chk({tag, "_araddr"}, 64'(araddr), 64'(a));
        chk({tag, "_arsize"}, 64'(arsize), 64'(sz));
        tick;
        chk({tag, "_rready"}, 64'(rready), 64'd1);
        chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        rvalid = 1; rdata = rd; rresp = rr;
        tick;
        rvalid = 0; rresp = 0;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_out_data"}, out_data, exp_d);
        chk({tag, "_out_err"}, 64'(out_err), 64'(exp_c != 2'b00));
        chk({tag, "_err_code"}, 64'(out_err_code), 64'(exp_c));
    endtask

    task automatic release_out;
        out_ready = 1;
        tick;
        out_ready = 0;
        chk("back_to_idle", 64'(in_ready), 64'd1);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_wstrb", 64'(wstrb), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        rst = 1;
        tick;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        in_rd = 5'd7; in_reg_we = 1;
        do_load("ld_sb", 32'h8000_0005, 2'd0, 1'b1, 64'h0000_8000_0000_0000, 2'b00,
                64'hFFFF_FFFF_FFFF_FF80, 2'b00);
        chk("ld_sb_rd", 64'(out_rd), 64'd7);
        chk("ld_sb_in_ready", 64'(in_ready), 64'd0);
        release_out;
        do_load("ld_hu", 32'h1000_0002, 2'd1, 1'b0, 64'h0000_0000_F00D_0000, 2'b00,
                64'h0000_0000_0000_F00D, 2'b00);
        release_out;
        do_load("ld_d", 32'h1000_0008, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 2'b00,
                64'h8000_0000_0000_0001, 2'b00);
        release_out;

        // Store with AW delayed three cycles behind W
        snap_aw = aw_cnt; snap_w = w_cnt;
        in_valid = 1; in_wen = 1; in_size = 2'd1; in_addr = 32'h8000_0006;
        in_wdata = 64'h0000_0000_0000_BEEF; awready = 0; wready = 1;
        tick;
        in_valid = 0; in_wen = 0;
        chk("st_awvalid", 64'(awvalid), 64'd1);
        chk("st_wvalid", 64'(wvalid), 64'd1);
        chk("st_awaddr", 64'(awaddr), 64'h8000_0006);
        chk("st_wdata", wdata, 64'hBEEF_0000_0000_0000);
        chk("st_wstrb", 64'(wstrb), 64'hC0);
        tick;
        chk("st_wvalid_drop", 64'(wvalid), 64'd0);
        chk("st_awvalid_hold", 64'(awvalid), 64'd1);
        tick;
        tick;
        chk("st_awvalid_hold2", 64'(awvalid), 64'd1);
        awready = 1;
        tick;
        awready = 0;
        chk("st_awvalid_drop", 64'(awvalid), 64'd0);
        chk("st_bready", 64'(bready), 64'd1);
        chk("st_no_early_valid", 64'(out_valid), 64'd0);
        bvalid = 1;
        tick;
        bvalid = 0;
        chk("st_out_valid", 64'(out_valid), 64'd1);
        chk("st_out_err", 64'(out_err), 64'd0);
        chk("st_aw_count", 64'(aw_cnt - snap_aw), 64'd1);
        chk("st_w_count", 64'(w_cnt - snap_w), 64'd1);
        release_out;

        // Pass-through
        in_valid = 1; in_wdata = 64'h1234_5678_9ABC_DEF0;
        tick;
        in_valid = 0;
        chk("pt_out_valid", 64'(out_valid), 64'd1);
        chk("pt_out_data", out_data, 64'h1234_5678_9ABC_DEF0);
        chk("pt_out_err", 64'(out_err), 64'd0);
        release_out;

        // Misaligned word load
        snap_ar = ar_cnt;
        in_valid = 1; in_ren = 1; in_size = 2'd2; in_addr = 32'h8000_0002;
        tick;
        in_valid = 0; in_ren = 0;
        chk("mis_out_valid", 64'(out_valid), 64'd1);
        chk("mis_out_err", 64'(out_err), 64'd1);
        chk("mis_code", 64'(out_err_code), 64'd1);
        chk("mis_arvalid", 64'(arvalid), 64'd0);
        release_out;
        chk("mis_ar_count", 64'(ar_cnt - snap_ar), 64'd0);

        // Illegal cases on the 32-bit instance
        s_in_valid = 1; s_in_ren = 1; s_in_size = 2'd3;
        tick;
        s_in_valid = 0; s_in_ren = 0;
        chk("ill_size_valid", 64'(s_out_valid), 64'd1);
        chk("ill_size_code", 64'(s_out_err_code), 64'd3);
        tick;
        s_in_valid = 1; s_in_ren = 1; s_in_wen = 1; s_in_size = 2'd2;
        tick;
        s_in_valid = 0; s_in_ren = 0; s_in_wen = 0;
        chk("ill_rw_valid", 64'(s_out_valid), 64'd1);
        chk("ill_rw_code", 64'(s_out_err_code), 64'd3);
        tick;
        chk("ill_bus_count", 64'(s_bus_cnt), 64'd0);

        // Bus error with a stalled consumer
        do_load("berr", 32'h2000_0000, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 2'b10,
                64'd0, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("berr_hold_valid", 64'(out_valid), 64'd1);
            chk("berr_hold_data", out_data, 64'd0);
            chk("berr_hold_code", 64'(out_err_code), 64'd2);
            chk("berr_in_ready", 64'(in_ready), 64'd0);
        end
        release_out;

        // Reset in the middle of an AR request
        arready = 0;
        in_valid = 1; in_ren = 1; in_size = 2'd2; in_addr = 32'h3000_0004;
        tick;
        in_valid = 0; in_ren = 0;
        chk("mrst_arvalid_pre", 64'(arvalid), 64'd1);
        #2 rst = 0;
        #1;
        chk("mrst_arvalid_async", 64'(arvalid), 64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        #2 rst = 1;
        tick;
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_no_result", 64'(out_valid), 64'd0);
        do_load("post_rst", 32'h3000_0004, 2'd2, 1'b1, 64'h1234_5678_8765_4321, 2'b00,
                64'h0000_0000_1234_5678, 2'b00);
        release_out;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
